// File: rtl/matmul_stream_driver_pkg.sv
// rtl/matmul_stream_driver_pkg.sv - shared states and constants for the matmul stream driver
package matmul_stream_driver_pkg;

  localparam int NUM_ELEM  = 16;
  localparam int IDX_WIDTH = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    RECV   = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/matmul_stream_tx.sv
// rtl/matmul_stream_tx.sv - AXIS master beat generator for one operand channel
// Presents elem_i for the current index and advances only on a completed handshake.
module matmul_stream_tx
  import matmul_stream_driver_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pNUM_ELEM   = NUM_ELEM,
  parameter int pIDX_WIDTH  = IDX_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   active_i,
  input  logic [pDATA_WIDTH-1:0] elem_i,
  input  logic                   tready_i,
  output logic [pIDX_WIDTH-1:0]  idx_o,
  output logic                   tvalid_o,
  output logic [pDATA_WIDTH-1:0] tdata_o,
  output logic                   tlast_o,
  output logic                   last_hs_o
);

  localparam logic [pIDX_WIDTH-1:0] LAST_IDX = pIDX_WIDTH'(pNUM_ELEM - 1);

  logic [pIDX_WIDTH-1:0] idx_q, idx_d;
  logic                  hs;
  logic                  at_last;

  // tvalid follows the channel state only; data holds because idx moves only on handshake.
  assign tvalid_o  = active_i;
  assign at_last   = (idx_q == LAST_IDX);
  assign tlast_o   = active_i && at_last;
  assign tdata_o   = active_i ? elem_i : '0;
  assign hs        = active_i && tready_i;
  assign last_hs_o = hs && at_last;
  assign idx_o     = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (hs) begin
      idx_d = at_last ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/matmul_stream_driver.sv
// rtl/matmul_stream_driver.sv - AXIS front end for the 4x4 matrix-multiply engine
// Streams the A then B operand buffers to the engine and captures its result stream into C.
module matmul_stream_driver
  import matmul_stream_driver_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pNUM_ELEM   = NUM_ELEM,
  parameter int pIDX_WIDTH  = IDX_WIDTH
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_we,
  input  logic                   cfg_sel,
  input  logic [pIDX_WIDTH-1:0]  cfg_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  input  logic [pIDX_WIDTH-1:0]  cfg_raddr,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err_tlast,
  output logic                   ms_tvalid_A,
  output logic [pDATA_WIDTH-1:0] ms_tdata_A,
  output logic                   ms_tlast_A,
  input  logic                   ms_tready_A,
  output logic                   ms_tvalid_B,
  output logic [pDATA_WIDTH-1:0] ms_tdata_B,
  output logic                   ms_tlast_B,
  input  logic                   ms_tready_B,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready
);

  localparam logic [pIDX_WIDTH-1:0] LAST_IDX = pIDX_WIDTH'(pNUM_ELEM - 1);

  state_e                 state_q, state_d;
  logic [pIDX_WIDTH-1:0]  rx_idx_q, rx_idx_d;
  logic                   err_q, err_d;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [pDATA_WIDTH-1:0] a_mem_q [pNUM_ELEM];
  logic [pDATA_WIDTH-1:0] b_mem_q [pNUM_ELEM];
  logic [pDATA_WIDTH-1:0] c_mem_q [pNUM_ELEM];
  logic [pIDX_WIDTH-1:0]  a_idx, b_idx;
  logic                   a_last_hs, b_last_hs;
  logic                   rx_beat, rx_last, cfg_wr;

  assign busy      = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == RECV);
  assign done      = (state_q == DONE);
  assign ss_tready = (state_q == RECV);
  assign err_tlast = err_q;
  assign cfg_rdata = rdata_q;
  assign rx_beat   = ss_tready && ss_tvalid;
  assign rx_last   = (rx_idx_q == LAST_IDX);
  assign cfg_wr    = cfg_we && !busy;

  matmul_stream_tx #(
    .pDATA_WIDTH(pDATA_WIDTH),
    .pNUM_ELEM  (pNUM_ELEM),
    .pIDX_WIDTH (pIDX_WIDTH)
  ) u_tx_a (
    .clk_i    (axis_clk),
    .rst_i    (axis_rst),
    .active_i (state_q == SEND_A),
    .elem_i   (a_mem_q[a_idx]),
    .tready_i (ms_tready_A),
    .idx_o    (a_idx),
    .tvalid_o (ms_tvalid_A),
    .tdata_o  (ms_tdata_A),
    .tlast_o  (ms_tlast_A),
    .last_hs_o(a_last_hs)
  );

  matmul_stream_tx #(
    .pDATA_WIDTH(pDATA_WIDTH),
    .pNUM_ELEM  (pNUM_ELEM),
    .pIDX_WIDTH (pIDX_WIDTH)
  ) u_tx_b (
    .clk_i    (axis_clk),
    .rst_i    (axis_rst),
    .active_i (state_q == SEND_B),
    .elem_i   (b_mem_q[b_idx]),
    .tready_i (ms_tready_B),
    .idx_o    (b_idx),
    .tvalid_o (ms_tvalid_B),
    .tdata_o  (ms_tdata_B),
    .tlast_o  (ms_tlast_B),
    .last_hs_o(b_last_hs)
  );

  always_comb begin
    state_d  = state_q;
    rx_idx_d = rx_idx_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SEND_A;
          rx_idx_d = '0;
          err_d    = 1'b0;
        end
      end
      SEND_A: if (a_last_hs) state_d = SEND_B;
      SEND_B: if (b_last_hs) state_d = RECV;
      RECV: begin
        if (ss_tvalid) begin
          rx_idx_d = rx_last ? '0 : rx_idx_q + 1'b1;
          // Framing must match the beat count exactly: tlast on the final beat and nowhere else.
          if (ss_tlast != rx_last) err_d = 1'b1;
          if (rx_last) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q  <= IDLE;
      rx_idx_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rx_idx_q <= rx_idx_d;
      err_q    <= err_d;
      rdata_q  <= c_mem_q[cfg_raddr];
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      for (int i = 0; i < pNUM_ELEM; i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      if (cfg_sel == SEL_B) b_mem_q[cfg_addr] <= cfg_wdata;
      else                  a_mem_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      for (int i = 0; i < pNUM_ELEM; i++) begin
        c_mem_q[i] <= '0;
      end
    end else if (rx_beat) begin
      c_mem_q[rx_idx_q] <= ss_tdata;
    end
  end

endmodule

// File: tb/tb_matmul_stream_driver.sv
// tb/tb_matmul_stream_driver.sv - directed self-checking bench for matmul_stream_driver
module tb_matmul_stream_driver;

  logic        axis_clk;
  logic        axis_rst;
  logic        cfg_we;
  logic        cfg_sel;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [3:0]  cfg_raddr;
  logic [31:0] cfg_rdata;
  logic        start;
  logic        busy;
  logic        done;
  logic        err_tlast;
  logic        ms_tvalid_A;
  logic [31:0] ms_tdata_A;
  logic        ms_tlast_A;
  logic        ms_tready_A;
  logic        ms_tvalid_B;
  logic [31:0] ms_tdata_B;
  logic        ms_tlast_B;
  logic        ms_tready_B;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;

  int n_checks;
  int n_fail;

  logic [31:0] a_ld  [16];
  logic [31:0] b_ld  [16];
  logic [31:0] exp_c [16];

  matmul_stream_driver dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_raddr  (cfg_raddr),
    .cfg_rdata  (cfg_rdata),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err_tlast  (err_tlast),
    .ms_tvalid_A(ms_tvalid_A),
    .ms_tdata_A (ms_tdata_A),
    .ms_tlast_A (ms_tlast_A),
    .ms_tready_A(ms_tready_A),
    .ms_tvalid_B(ms_tvalid_B),
    .ms_tdata_B (ms_tdata_B),
    .ms_tlast_B (ms_tlast_B),
    .ms_tready_B(ms_tready_B),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_one(input logic sel, input logic [3:0] addr, input logic [31:0] val);
    @(negedge axis_clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = val;
    @(negedge axis_clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) write_one(1'b0, 4'(i), a_ld[i]);
    for (int i = 0; i < 16; i++) write_one(1'b1, 4'(i), b_ld[i]);
  endtask

  task automatic do_start();
    @(negedge axis_clk);
    start = 1'b1;
    @(negedge axis_clk);
    start = 1'b0;
    check_eq("start_flags", 64'({ms_tvalid_A, busy, done, err_tlast}), 64'(4'b1100));
  endtask

  task automatic start_with_write(input logic [31:0] val);
    @(negedge axis_clk);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_wdata = val; start = 1'b1;
    @(negedge axis_clk);
    cfg_we = 1'b0; start = 1'b0;
    check_eq("start_wr_flags", 64'({ms_tvalid_A, busy, done}), 64'(3'b110));
    check_eq("start_wr_beat0", 64'(ms_tdata_A), 64'(val));
  endtask

  task automatic calc_exp();
    logic [31:0] s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int k = 0; k < 4; k++) s += a_ld[r*4+k] * b_ld[k*4+c];
        exp_c[r*4+c] = s;
      end
    end
  endtask

  task automatic read_c(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge axis_clk);
      cfg_raddr = 4'(i);
      @(negedge axis_clk);
      check_eq($sformatf("%s_c%0d", tag, i), 64'(cfg_rdata), 64'(exp_c[i]));
    end
  endtask

  // Engine model: sinks A and B (optionally with backpressure), returns A*B on the result stream.
  task automatic run_engine(input bit bp, input int bad_beat, input int rst_after_b, input bit poke);
    logic [31:0] got_a [16];
    logic [31:0] got_b [16];
    logic [31:0] c_mod [16];
    logic [32:0] hold_va, hold_vb;
    logic        hold_a, hold_b;
    logic [31:0] s;
    int na, nb, nc, cyc, stab_err, excl_err, order_err, last_err;
    bit aborted;
    na = 0; nb = 0; nc = 0; cyc = 0;
    stab_err = 0; excl_err = 0; order_err = 0; last_err = 0;
    hold_a = 1'b0; hold_b = 1'b0; hold_va = '0; hold_vb = '0; aborted = 1'b0;
    while (nb < 16 && cyc < 400 && !aborted) begin
      if (hold_a && (!ms_tvalid_A || {ms_tlast_A, ms_tdata_A} != hold_va)) stab_err++;
      if (hold_b && (!ms_tvalid_B || {ms_tlast_B, ms_tdata_B} != hold_vb)) stab_err++;
      if (int'(ms_tvalid_A) + int'(ms_tvalid_B) + int'(ss_tready) > 1) excl_err++;
      if (ms_tvalid_B && na < 16) order_err++;
      ms_tready_A = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ms_tready_B = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hold_a = ms_tvalid_A && !ms_tready_A; hold_va = {ms_tlast_A, ms_tdata_A};
      hold_b = ms_tvalid_B && !ms_tready_B; hold_vb = {ms_tlast_B, ms_tdata_B};
      if (ms_tvalid_A && ms_tready_A && na < 16) begin
        got_a[na] = ms_tdata_A;
        if (ms_tlast_A != (na == 15)) last_err++;
        na++;
      end
      if (ms_tvalid_B && ms_tready_B && nb < 16) begin
        got_b[nb] = ms_tdata_B;
        if (ms_tlast_B != (nb == 15)) last_err++;
        nb++;
      end
      if (rst_after_b > 0 && nb == rst_after_b) aborted = 1'b1;
      else begin
        @(negedge axis_clk);
        cyc++;
      end
    end
    if (aborted) begin
      check_eq("pre_rst_valid_b", 64'(ms_tvalid_B), 64'd1);
      @(posedge axis_clk);
      #2;
      axis_rst = 1'b1;
      #1;
      check_eq("rst_async_flags", 64'({ms_tvalid_A, ms_tvalid_B, busy, done, ss_tready}), 64'd0);
      check_eq("rst_async_tdata", 64'(ms_tdata_B), 64'd0);
      ms_tready_A = 1'b0; ms_tready_B = 1'b0;
    end else begin
      ms_tready_A = 1'b0; ms_tready_B = 1'b0;
      check_eq("a_count", 64'(na), 64'd16);
      check_eq("b_count", 64'(nb), 64'd16);
      check_eq("hold_stable", 64'(stab_err), 64'd0);
      check_eq("b_after_a", 64'(order_err), 64'd0);
      check_eq("tlast_pos", 64'(last_err), 64'd0);
      if (!bp) check_eq("send_cycles", 64'(cyc), 64'd32);
      for (int i = 0; i < 16; i++) begin
        check_eq($sformatf("a_beat%0d", i), 64'(got_a[i]), 64'(a_ld[i]));
        check_eq($sformatf("b_beat%0d", i), 64'(got_b[i]), 64'(b_ld[i]));
      end
      check_eq("recv_entry", 64'({ss_tready, busy, done}), 64'(3'b110));
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          s = '0;
          for (int k = 0; k < 4; k++) s += got_a[r*4+k] * got_b[k*4+c];
          c_mod[r*4+c] = s;
        end
      end
      cyc = 0;
      while (nc < 16 && cyc < 200) begin
        if (int'(ms_tvalid_A) + int'(ms_tvalid_B) + int'(ss_tready) > 1) excl_err++;
        start = poke && (nc == 8);
        cfg_we = start; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_wdata = 32'hDEAD;
        if (bp && $urandom_range(0, 3) == 0) ss_tvalid = 1'b0;
        else begin
          ss_tvalid = 1'b1;
          ss_tdata  = c_mod[nc];
          ss_tlast  = (nc == 15) ^ (nc == bad_beat);
          nc++;
        end
        @(negedge axis_clk);
        cyc++;
      end
      start = 1'b0; cfg_we = 1'b0;
      check_eq("excl_valid", 64'(excl_err), 64'd0);
      check_eq("done_after_last", 64'({done, busy, ss_tready}), 64'(3'b100));
      ss_tvalid = 1'b1; ss_tdata = 32'hBAD; ss_tlast = 1'b1;
      @(negedge axis_clk);
      ss_tvalid = 1'b0; ss_tlast = 1'b0; ss_tdata = '0;
      check_eq("err_tlast", 64'(err_tlast), 64'(bad_beat >= 0));
      check_eq("done_sticky", 64'(done), 64'd1);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    axis_rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_raddr = '0; start = 1'b0; ms_tready_A = 1'b0; ms_tready_B = 1'b0;
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
    repeat (2) @(negedge axis_clk);
    check_eq("rst_flags", 64'({busy, done, err_tlast, ss_tready, ms_tvalid_A, ms_tlast_A,
                               ms_tvalid_B, ms_tlast_B}), 64'd0);
    check_eq("rst_rdata", 64'(cfg_rdata), 64'd0);
    check_eq("rst_tdata", 64'(ms_tdata_A | ms_tdata_B), 64'd0);
    axis_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      a_ld[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
      b_ld[i] = 32'(i + 1);
      exp_c[i] = 32'(i + 1);
    end
    load_all();
    do_start();
    run_engine(1'b0, -1, 0, 1'b0);
    read_c("ident");

    for (int i = 0; i < 16; i++) begin
      a_ld[i] = 32'(3 * i + 1);
      b_ld[i] = 32'(16 - i);
    end
    load_all();
    do_start();
    run_engine(1'b1, -1, 0, 1'b0);
    calc_exp();
    read_c("bp");

    for (int i = 0; i < 16; i++) b_ld[i] = 32'(i + 7);
    load_all();
    do_start();
    run_engine(1'b0, 7, 0, 1'b0);
    calc_exp();
    read_c("frm8");

    for (int i = 0; i < 16; i++) b_ld[i] = 32'(2 * i + 3);
    load_all();
    do_start();
    run_engine(1'b1, 15, 0, 1'b0);
    calc_exp();
    read_c("frm16");

    do_start();
    run_engine(1'b0, -1, 0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      b_ld[i] = 32'(i * i + 2);
      write_one(1'b1, 4'(i), b_ld[i]);
    end
    do_start();
    run_engine(1'b0, -1, 0, 1'b0);
    calc_exp();
    read_c("b2b");

    a_ld[0] = 32'hDEAD;
    write_one(1'b0, 4'd0, a_ld[0]);
    do_start();
    run_engine(1'b0, -1, 0, 1'b0);
    calc_exp();
    read_c("dead");

    do_start();
    run_engine(1'b0, -1, 5, 1'b0);
    @(negedge axis_clk);
    @(negedge axis_clk);
    axis_rst = 1'b0;
    check_eq("post_rst_flags", 64'({busy, done, err_tlast, ms_tvalid_A, ss_tready}), 64'd0);
    for (int i = 0; i < 16; i++) exp_c[i] = '0;
    read_c("rst");

    for (int i = 0; i < 16; i++) begin
      a_ld[i] = 32'(i + 5);
      b_ld[i] = 32'(2 * i);
    end
    a_ld[0] = 32'h1234;
    for (int i = 1; i < 16; i++) write_one(1'b0, 4'(i), a_ld[i]);
    for (int i = 0; i < 16; i++) write_one(1'b1, 4'(i), b_ld[i]);
    start_with_write(a_ld[0]);
    run_engine(1'b0, -1, 0, 1'b0);
    calc_exp();
    read_c("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_stream_driver.md
Name: matmul_stream_driver

Overview:
- AXI-Stream front end for the 4x4 matrix-multiply engine.
- CPU loads the A and B operand buffers (16 words each, row-major) through a simple register port, then pulses start.
- Block streams A, then B, into the engine's two slave inputs and captures the 16 result beats from the engine's master output into a C buffer.
- CPU reads the results back through the same port; done/busy/err flags report status.

Parameters:
- pDATA_WIDTH, 32, width of matrix elements and stream data
- pNUM_ELEM, 16, elements per matrix; fixed 4x4, beats per stream
- pIDX_WIDTH, 4, log2(pNUM_ELEM), buffer index width

Ports:
- axis_clk  in  1  sole clock, rising edge
- axis_rst  in  1  reset; one clock; reset is asynchronous and active-high
- cfg_we  in  1  write strobe for operand buffers
- cfg_sel  in  1  0 = A buffer, 1 = B buffer
- cfg_addr  in  pIDX_WIDTH  element index for write
- cfg_wdata  in  pDATA_WIDTH  element value
- cfg_raddr  in  pIDX_WIDTH  C buffer read index
- cfg_rdata  out  pDATA_WIDTH  C[cfg_raddr], registered
- start  in  1  single-cycle launch pulse
- busy  out  1  high from start acceptance until DONE
- done  out  1  sticky completion flag
- err_tlast  out  1  sticky result-framing error
- ms_tvalid_A / ms_tdata_A / ms_tlast_A  out  1/pDATA_WIDTH/1  A stream to engine
- ms_tready_A  in  1
- ms_tvalid_B / ms_tdata_B / ms_tlast_B  out  1/pDATA_WIDTH/1  B stream to engine
- ms_tready_B  in  1
- ss_tvalid / ss_tdata / ss_tlast  in  1/pDATA_WIDTH/1  result stream from engine
- ss_tready  out  1

Behaviour:
- Reset (any time, including mid-transfer):
  - FSM to IDLE; idx counter = 0.
  - A, B and C buffers cleared to 0.
  - All outputs 0: busy, done, err_tlast, cfg_rdata, every tvalid/tlast/tdata, ss_tready.
- FSM states: IDLE, SEND_A, SEND_B, RECV, DONE.
  - IDLE: start=1 -> SEND_A next cycle, busy=1, done cleared, err_tlast cleared, idx=0.
  - SEND_A:
    - ms_tvalid_A=1, ms_tdata_A=A[idx], ms_tlast_A=(idx==15).
    - Handshake = tvalid & tready. On each handshake idx++.
    - Handshake at idx==15 -> idx=0, SEND_B.
  - SEND_B: identical on the B channel, using B[idx]; handshake at idx==15 -> idx=0, RECV.
  - RECV:
    - ss_tready=1. On ss_tvalid, write C[idx]=ss_tdata and idx++.
    - Beat at idx==15 -> DONE.
    - err_tlast set if ss_tlast=1 on a beat with idx!=15, or ss_tlast=0 on the beat with idx==15.
  - DONE: busy=0, done=1, ss_tready=0. start=1 -> SEND_A, same as from IDLE.
- AXIS rules:
  - tvalid never depends combinationally on tready.
  - Once tvalid is asserted, data and tlast stay stable until the handshake completes.
  - Only one of ms_tvalid_A, ms_tvalid_B, ss_tready is high in any cycle.
- Latency:
  - start sampled in cycle N -> ms_tvalid_A high in cycle N+1.
  - With zero backpressure: A occupies 16 cycles, B 16 cycles, RECV at least 16 cycles.
  - done rises in the cycle after the 16th result handshake.
- cfg_rdata: registered, 1-cycle read latency; readable in any state (mid-RECV reads return the partially filled buffer).
- cfg_we:
  - Ignored while busy=1.
  - Accepted in IDLE and DONE; cfg_addr wraps naturally within 4 bits.
- start while busy=1: ignored, no effect.
- Extra result beats after the 16th: not accepted, because ss_tready=0 in DONE.
- Simultaneous cfg_we and start in IDLE: the write lands in the buffer and start is accepted. Streaming begins the next cycle and uses the new value.
- The engine's result values are not checked; this block only transports them.

Decomposition:
- Shared package:
  - FSM state encodings (IDLE=0, SEND_A=1, SEND_B=2, RECV=3, DONE=4)
  - pNUM_ELEM and pIDX_WIDTH constants
  - cfg_sel encodings
- One natural sub-module: matmul_stream_tx, the AXIS master beat generator (valid/last/hold logic, idx counter).
  - Instantiated once and muxed between A and B, or twice, one per channel.
- Buffers and RECV capture stay in the top.

Test Plan:
- Identity test:
  - Stimulus: load A = identity (A[0]=A[5]=A[10]=A[15]=1, else 0) and B[i]=i+1; start; engine model returns A*B.
  - Required response: A beats 1,0,0,0,0,1,..., tlast only on beat 16; then B beats 1..16; C[i]=i+1; done=1; err_tlast=0.
- Backpressure test:
  - Stimulus: ms_tready_A/B toggled pseudo-randomly (~50%).
  - Required response: tdata/tlast never change while tvalid=1 and tready=0; exactly 16 handshakes per channel; B never starts before the 16th A handshake.
- Framing error test:
  - Stimulus: engine model asserts ss_tlast on result beat 8, and in a second run omits it on beat 16.
  - Required response: err_tlast=1 in both runs; C still holds all 16 beats; done=1.
- Reset mid-transfer test:
  - Stimulus: assert axis_rst after 5 B beats (asynchronous, mid-cycle).
  - Required response: all tvalid, busy, done and ss_tready fall immediately; after release the FSM is in IDLE, C reads 0, and a fresh start completes normally.
- Start/write while busy test:
  - Stimulus: pulse start and cfg_we (A[0]=0xDEAD) during RECV.
  - Required response: both ignored; run completes; cfg_we to A[0] in DONE then succeeds, and a second start streams 0xDEAD as A beat 1.
- Back-to-back runs test:
  - Stimulus: start issued in the DONE state.
  - Required response: done clears the next cycle, ms_tvalid_A=1 the next cycle, and the second result overwrites C.
